// File: rtl/ram_bank.sv
// ram_bank: DEPTH x WIDTH register array with req/ack access, registered read port
// and a sequenced word-by-word bulk clear.
module ram_bank #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             rw,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_all,
  output logic [WIDTH-1:0] dout,
  output logic             ack,
  output logic             err,
  output logic             busy
);
  typedef enum logic {IDLE, CLEAR} state_t;
  // one extra bit so a power-of-two DEPTH still compares cleanly
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ack_q, ack_d, err_q, err_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             we, in_range, last;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  assign in_range = {1'b0, addr} < DEPTH_W;
  assign last     = ptr_q == LAST;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dout_d  = dout_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    we      = 1'b0;
    wa      = addr;
    wd      = din;
    if (state_q == CLEAR) begin
      we      = 1'b1;
      wa      = ptr_q;
      wd      = '0;
      ptr_d   = last ? '0 : ptr_q + 1'b1;
      state_d = last ? IDLE : CLEAR;
    end else if (clr_all) begin
      state_d = CLEAR;
      ptr_d   = '0;
    end else if (req) begin
      ack_d  = 1'b1;
      err_d  = !in_range;
      we     = rw && in_range;
      dout_d = rw ? dout_q : (in_range ? mem_q[addr] : '0);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (we) mem_q[wa] <= wd;
    end
  end
  assign dout = dout_q;
  assign ack  = ack_q;
  assign err  = err_q;
  assign busy = state_q == CLEAR;
endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank: drives a DEPTH=4 and a DEPTH=3 ram_bank with identical stimulus and
// compares every cycle against an array-based reference model.
module tb_ram_bank;
  logic        clk = 0, reset = 1, req = 0, rw = 0, clr_all = 0;
  logic [1:0]  addr = 0;
  logic [15:0] din = 0;
  logic [15:0] dout4, dout3;
  logic        ack4, err4, busy4, ack3, err3, busy3;
  int errors = 0, checks = 0;
  logic [15:0] m [2][4];
  logic [15:0] e_dout [2];
  logic        e_ack [2], e_err [2];
  int          left [2];
  int          dep [2] = '{4, 3};

  always #5 clk = ~clk;

  ram_bank #(.WIDTH(16), .DEPTH(4)) u4 (.clk(clk), .reset(reset), .req(req), .rw(rw),
    .addr(addr), .din(din), .clr_all(clr_all), .dout(dout4), .ack(ack4), .err(err4), .busy(busy4));
  ram_bank #(.WIDTH(16), .DEPTH(3)) u3 (.clk(clk), .reset(reset), .req(req), .rw(rw),
    .addr(addr), .din(din), .clr_all(clr_all), .dout(dout3), .ack(ack3), .err(err3), .busy(busy3));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " dout4"}, dout4, e_dout[0]);
    chk({tag, " ack4"}, 16'(ack4), 16'(e_ack[0]));
    chk({tag, " err4"}, 16'(err4), 16'(e_err[0]));
    chk({tag, " busy4"}, 16'(busy4), 16'(left[0] > 0));
    chk({tag, " dout3"}, dout3, e_dout[1]);
    chk({tag, " ack3"}, 16'(ack3), 16'(e_ack[1]));
    chk({tag, " err3"}, 16'(err3), 16'(e_err[1]));
    chk({tag, " busy3"}, 16'(busy3), 16'(left[1] > 0));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m[k][i] = '0;
      e_dout[k] = '0;
      e_ack[k]  = 0;
      e_err[k]  = 0;
      left[k]   = 0;
    end
  endtask

  // A clear zeroes the whole array at once: nothing can observe the array while busy.
  task automatic model_edge(input logic rq, input logic w, input logic [1:0] a,
                            input logic [15:0] d, input logic c);
    for (int k = 0; k < 2; k++) begin
      e_ack[k] = 0;
      e_err[k] = 0;
      if (left[k] > 0) left[k]--;
      else if (c) begin
        for (int i = 0; i < 4; i++) m[k][i] = '0;
        left[k] = dep[k];
      end else if (rq) begin
        e_ack[k] = 1;
        e_err[k] = int'(a) >= dep[k];
        if (w && !e_err[k]) m[k][a] = d;
        if (!w) e_dout[k] = e_err[k] ? 16'h0 : m[k][a];
      end
    end
  endtask

  task automatic step(input string tag, input logic rq, input logic w, input logic [1:0] a,
                      input logic [15:0] d, input logic c);
    @(negedge clk);
    req = rq; rw = w; addr = a; din = d; clr_all = c;
    @(posedge clk);
    model_edge(rq, w, a, d, c);
    #1 check_all(tag);
  endtask

  initial begin
    model_reset();
    #2 reset = 0;
    #1 check_all("reset");
    @(negedge clk) reset = 1;
    for (int i = 0; i < 4; i++) step("rst_read", 1, 0, 2'(i), 16'h0, 0);

    step("wr1", 1, 1, 2'd1, 16'h7001, 0);
    step("wr3", 1, 1, 2'd3, 16'h7000, 0);
    step("rd1", 1, 0, 2'd1, 16'h0, 0);
    step("rd3", 1, 0, 2'd3, 16'h0, 0);
    step("idle", 0, 0, 2'd0, 16'h0, 0);

    step("oor_wr", 1, 1, 2'd3, 16'hFFFF, 0);
    step("oor_rd", 1, 0, 2'd3, 16'h0, 0);
    for (int i = 0; i < 3; i++) step("oor_keep", 1, 0, 2'(i), 16'h0, 0);

    step("fill0", 1, 1, 2'd0, 16'h6CCC, 0);
    step("fill1", 1, 1, 2'd1, 16'h6F0F, 0);
    step("fill2", 1, 1, 2'd2, 16'h6FFF, 0);
    step("fill3", 1, 1, 2'd3, 16'h6AAA, 0);
    step("clr", 0, 0, 2'd0, 16'h0, 1);
    for (int i = 0; i < 4; i++) step("clr_hold", 1, 0, 2'd1, 16'h0, 0);
    for (int i = 0; i < 4; i++) step("clr_rd", 1, 0, 2'(i), 16'h0, 0);

    step("prio", 1, 1, 2'd2, 16'h1234, 1);
    for (int i = 0; i < 4; i++) step("prio_wait", 0, 0, 2'd0, 16'h0, 0);
    step("prio_rd", 1, 0, 2'd2, 16'h0, 0);

    for (int i = 0; i < 4; i++) step("fillA5", 1, 1, 2'(i), 16'hA5A5, 0);
    step("rd_a5", 1, 0, 2'd2, 16'h0, 0);
    step("clr2", 0, 0, 2'd0, 16'h0, 1);
    step("clr2_b", 0, 0, 2'd0, 16'h0, 0);
    step("clr2_c", 0, 0, 2'd0, 16'h0, 0);
    req = 0; clr_all = 0;
    #2 reset = 0;
    model_reset();
    #1 check_all("rst_mid");
    @(negedge clk) reset = 1;
    for (int i = 0; i < 4; i++) step("rst_mid_rd", 1, 0, 2'(i), 16'h0, 0);

    for (int i = 0; i < 300; i++)
      step("rand", $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 16'($urandom), $urandom_range(0, 24) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
